// File: rtl/shadow_context_unit.sv
// Shadow-register save/restore engine for the fast-interrupt path.
// Stores a frame of shadow registers below the stack pointer through one
// D-cache port on interrupt entry and reloads the newest frame on return.
// A small frame-pointer stack lets frames nest NUM_LEVELS deep.
//
// D-cache handshake: a request is held (data_req, address, write data all
// stable) until the cycle data_gnt is seen high; a load is followed by one
// tag_valid cycle and then completes on the first data_rvalid cycle.
package shadow_context_pkg;
    localparam int XLEN               = 32;
    localparam int PLEN               = 34;
    localparam int DCACHE_INDEX_WIDTH = 12;
    localparam int DCACHE_TAG_WIDTH   = PLEN - DCACHE_INDEX_WIDTH;

    // Request towards the D-cache.
    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [XLEN-1:0]               data_wdata;
        logic [XLEN-1:0]               data_wuser;
        logic                          data_req;
        logic                          data_we;
        logic [XLEN/8-1:0]             data_be;
        logic [1:0]                    data_size;
        logic [1:0]                    data_id;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    // Response from the D-cache.
    typedef struct packed {
        logic            data_gnt;
        logic            data_rvalid;
        logic [1:0]      data_id;
        logic [XLEN-1:0] data_rdata;
        logic [XLEN-1:0] data_ruser;
    } dcache_req_o_t;
endpackage

module shadow_context_unit
    import shadow_context_pkg::*;
#(
    parameter int ADDR_WIDTH       = 6,
    parameter int DATA_WIDTH       = XLEN,
    parameter int NUM_SHADOW_SAVES = 16,
    parameter int NUM_LEVELS       = 2,
    localparam int LW              = $clog2(NUM_LEVELS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  shadow_irq_i,
    input  logic                  shadow_ret_i,
    input  logic [DATA_WIDTH-1:0] shadow_sp_i,
    output logic                  shadow_ready_o,
    output logic [LW-1:0]         shadow_level_o,
    output logic                  shadow_done_o,
    output logic                  shadow_err_o,
    output logic [ADDR_WIDTH-1:0] shadow_reg_raddr_o,
    input  logic [DATA_WIDTH-1:0] shadow_reg_rdata_i,
    output logic                  shadow_reg_we_o,
    output logic [ADDR_WIDTH-1:0] shadow_reg_waddr_o,
    output logic [DATA_WIDTH-1:0] shadow_reg_wdata_o,
    input  logic [11:0]           page_offset_i,
    output logic                  page_offset_matches_o,
    input  dcache_req_o_t         dcache_req_i,
    output dcache_req_i_t         dcache_req_o,
    output logic [2:0]            dbg_state_o
);

    localparam int B = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(B);
    localparam logic [DATA_WIDTH-1:0] FRAME_SIZE = DATA_WIDTH'(NUM_SHADOW_SAVES * B);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(B - 1);
    localparam logic [11:0]           FRAME_SPAN = 12'((NUM_SHADOW_SAVES - 1) * B);
    localparam logic [ADDR_WIDTH-1:0] LAST_CNT   = ADDR_WIDTH'(NUM_SHADOW_SAVES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAVE    = 3'd1,
        S_LD_REQ  = 3'd2,
        S_LD_TAG  = 3'd3,
        S_LD_WAIT = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [LW-1:0]         level_q, level_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] fp_q [NUM_LEVELS];
    logic [DATA_WIDTH-1:0] fp_d [NUM_LEVELS];

    logic [DATA_WIDTH-1:0] sp_aligned;
    logic [DATA_WIDTH-1:0] fp_top;
    logic [PLEN-1:0]       paddr;
    logic [11:0]           frame_high;
    logic                  unused_ok;

    assign sp_aligned = shadow_sp_i & ALIGN_MASK;
    assign paddr      = PLEN'(addr_q);
    assign frame_high = base_q[11:0] + FRAME_SPAN;

    // Select the newest saved frame pointer (fp[level-1]).
    always_comb begin
        fp_top = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (LW'(i + 1) == level_q) fp_top = fp_q[i];
        end
    end

    // State, counters, address and frame stack registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            level_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            base_q  <= '0;
            for (int i = 0; i < NUM_LEVELS; i++) fp_q[i] <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            for (int i = 0; i < NUM_LEVELS; i++) fp_q[i] <= fp_d[i];
        end
    end

    // Next-state logic plus the D-cache and register-file drive.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        base_d  = base_q;
        fp_d    = fp_q;

        shadow_done_o      = 1'b0;
        shadow_err_o       = 1'b0;
        shadow_reg_we_o    = 1'b0;
        shadow_reg_waddr_o = cnt_q;
        shadow_reg_wdata_o = dcache_req_i.data_rdata;
        shadow_reg_raddr_o = cnt_q;

        dcache_req_o               = '0;
        dcache_req_o.address_index = paddr[DCACHE_INDEX_WIDTH-1:0];
        dcache_req_o.address_tag   = paddr[PLEN-1:DCACHE_INDEX_WIDTH];
        dcache_req_o.data_wdata    = shadow_reg_rdata_i;
        dcache_req_o.data_be       = '1;
        dcache_req_o.data_size     = (DATA_WIDTH == 64) ? 2'b11 : 2'b10;

        unique case (state_q)
            S_IDLE: begin
                // irq has priority; a simultaneous ret is dropped.
                if (shadow_irq_i) begin
                    if (level_q < LW'(NUM_LEVELS)) begin
                        state_d = S_SAVE;
                        addr_d  = sp_aligned - STEP;
                        base_d  = sp_aligned - FRAME_SIZE;
                        cnt_d   = LAST_CNT;
                    end else begin
                        shadow_err_o = 1'b1;
                    end
                end else if (shadow_ret_i) begin
                    if (level_q != '0) begin
                        state_d = S_LD_REQ;
                        addr_d  = fp_top;
                        base_d  = fp_top;
                        cnt_d   = '0;
                    end else begin
                        shadow_err_o = 1'b1;
                    end
                end
            end
            S_SAVE: begin
                dcache_req_o.data_req = 1'b1;
                dcache_req_o.data_we  = 1'b1;
                if (dcache_req_i.data_gnt) begin
                    if (cnt_q != '0) begin
                        cnt_d  = cnt_q - 1'b1;
                        addr_d = addr_q - STEP;
                    end else begin
                        for (int i = 0; i < NUM_LEVELS; i++) begin
                            if (LW'(i) == level_q) fp_d[i] = addr_q;
                        end
                        level_d       = level_q + 1'b1;
                        shadow_done_o = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
            end
            S_LD_REQ: begin
                dcache_req_o.data_req = 1'b1;
                if (dcache_req_i.data_gnt) state_d = S_LD_TAG;
            end
            S_LD_TAG: begin
                dcache_req_o.tag_valid = 1'b1;
                state_d                = S_LD_WAIT;
            end
            S_LD_WAIT: begin
                if (dcache_req_i.data_rvalid) begin
                    shadow_reg_we_o = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        level_d       = level_q - 1'b1;
                        shadow_done_o = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = addr_q + STEP;
                        state_d = S_LD_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Flag load-unit offsets that fall inside the frame currently moving.
    always_comb begin
        page_offset_matches_o = (state_q != S_IDLE) &&
                                (page_offset_i[11:3] >= base_q[11:3]) &&
                                (page_offset_i[11:3] <= frame_high[11:3]);
    end

    assign shadow_ready_o = (state_q == S_IDLE);
    assign shadow_level_o = level_q;
    assign dbg_state_o    = state_q;

    assign unused_ok = ^{dcache_req_i.data_id, dcache_req_i.data_ruser,
                         page_offset_i[2:0], frame_high[2:0],
                         base_q[DATA_WIDTH-1:12], base_q[2:0]};

endmodule

// File: tb/tb_shadow_context_unit.sv
// Directed bench for shadow_context_unit: single save, stalled restore,
// nesting/overflow, underflow, simultaneous requests, page-offset match and
// reset in the middle of a save.
module tb_shadow_context_unit;
    import shadow_context_pkg::*;

    localparam int N = 16;

    logic          clk;
    logic          rst_n;
    logic          irq;
    logic          ret;
    logic [31:0]   sp;
    logic          ready;
    logic [1:0]    level;
    logic          done;
    logic          err;
    logic [5:0]    raddr;
    logic [31:0]   rdata;
    logic          reg_we;
    logic [5:0]    waddr;
    logic [31:0]   wdata;
    logic [11:0]   page_off;
    logic          match;
    dcache_req_o_t dc_rsp;
    dcache_req_i_t dc_req;
    logic [2:0]    state;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [11:0] po_tab [4] = '{12'hFC8, 12'hF00, 12'hFFF, 12'hFB8};

    shadow_context_unit dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .shadow_irq_i          (irq),
        .shadow_ret_i          (ret),
        .shadow_sp_i           (sp),
        .shadow_ready_o        (ready),
        .shadow_level_o        (level),
        .shadow_done_o         (done),
        .shadow_err_o          (err),
        .shadow_reg_raddr_o    (raddr),
        .shadow_reg_rdata_i    (rdata),
        .shadow_reg_we_o       (reg_we),
        .shadow_reg_waddr_o    (waddr),
        .shadow_reg_wdata_o    (wdata),
        .page_offset_i         (page_off),
        .page_offset_matches_o (match),
        .dcache_req_i          (dc_rsp),
        .dcache_req_o          (dc_req),
        .dbg_state_o           (state)
    );

    // Shadow register file model: combinational read, content tagged by index.
    assign rdata = 32'hA500_0000 | {26'd0, raddr};

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h3C00_5A00;
    endfunction

    function automatic logic exp_match(input logic [31:0] base, input logic [11:0] off);
        logic [11:0] hi;
        hi = base[11:0] + 12'd60;
        return (off[11:3] >= base[11:3]) && (off[11:3] <= hi[11:3]);
    endfunction

    function automatic logic [63:0] req_addr();
        return 64'({dc_req.address_tag, dc_req.address_index});
    endfunction

    // Save frame at stack pointer s; gnt held high; stops after n_gnt grants.
    task automatic do_save(input logic [31:0] s, input int n_gnt, input logic with_ret);
        logic [31:0] base;
        base = s - 32'd64;
        sp   = s;
        irq  = 1'b1;
        ret  = with_ret;
        dc_rsp.data_gnt = 1'b1;
        @(negedge clk);
        chk("save_acc_ready", 64'(ready), 64'd1);
        chk("save_acc_err", 64'(err), 64'd0);
        chk("save_acc_req", 64'(dc_req.data_req), 64'd0);
        cyc_end();
        irq = 1'b0;
        ret = 1'b0;
        for (int k = 0; k < n_gnt; k++) begin
            page_off = po_tab[k % 4];
            @(negedge clk);
            chk("save_req", 64'(dc_req.data_req), 64'd1);
            chk("save_we", 64'(dc_req.data_we), 64'd1);
            chk("save_addr", req_addr(), 64'(s - 32'd4 - 32'(4 * k)));
            chk("save_raddr", 64'(raddr), 64'(N - 1 - k));
            chk("save_wdata", 64'(dc_req.data_wdata), 64'(32'hA500_0000 | 32'(N - 1 - k)));
            chk("save_ready", 64'(ready), 64'd0);
            chk("save_done", 64'(done), 64'(k == N - 1));
            chk("save_match", 64'(match), 64'(exp_match(base, page_off)));
            chk("save_tagv", 64'(dc_req.tag_valid), 64'd0);
            cyc_end();
        end
        dc_rsp.data_gnt = 1'b0;
        if (n_gnt == N) begin
            @(negedge clk);
            chk("save_end_ready", 64'(ready), 64'd1);
            chk("save_end_done", 64'(done), 64'd0);
            chk("save_end_req", 64'(dc_req.data_req), 64'd0);
            cyc_end();
        end
    endtask

    // Restore the frame expected at base; optional gnt/rvalid stalls.
    task automatic do_restore(input logic [31:0] base, input logic stall);
        logic [31:0] a;
        int gd;
        int rd;
        ret = 1'b1;
        @(negedge clk);
        chk("rst_acc_ready", 64'(ready), 64'd1);
        chk("rst_acc_err", 64'(err), 64'd0);
        cyc_end();
        ret = 1'b0;
        for (int k = 0; k < N; k++) begin
            a  = base + 32'(4 * k);
            gd = stall ? (k % 4) : 0;
            rd = stall ? ((k * 3 + 1) % 4) : 0;
            for (int s = 0; s < gd; s++) begin
                @(negedge clk);
                chk("ld_stall_req", 64'(dc_req.data_req), 64'd1);
                chk("ld_stall_addr", req_addr(), 64'(a));
                chk("ld_stall_done", 64'(done), 64'd0);
                cyc_end();
            end
            dc_rsp.data_gnt = 1'b1;
            @(negedge clk);
            chk("ld_req", 64'(dc_req.data_req), 64'd1);
            chk("ld_we", 64'(dc_req.data_we), 64'd0);
            chk("ld_addr", req_addr(), 64'(a));
            chk("ld_ready", 64'(ready), 64'd0);
            cyc_end();
            dc_rsp.data_gnt = 1'b0;
            @(negedge clk);
            chk("ld_tagv", 64'(dc_req.tag_valid), 64'd1);
            chk("ld_tag_req", 64'(dc_req.data_req), 64'd0);
            chk("ld_tag", 64'(dc_req.address_tag), 64'(a >> 12));
            cyc_end();
            for (int s = 0; s < rd; s++) begin
                @(negedge clk);
                chk("ld_wait_we", 64'(reg_we), 64'd0);
                chk("ld_wait_done", 64'(done), 64'd0);
                chk("ld_wait_tagv", 64'(dc_req.tag_valid), 64'd0);
                cyc_end();
            end
            dc_rsp.data_rvalid = 1'b1;
            dc_rsp.data_rdata  = mem_fn(a);
            exp_q.push_back(mem_fn(a));
            @(negedge clk);
            chk("ld_reg_we", 64'(reg_we), 64'd1);
            chk("ld_waddr", 64'(waddr), 64'(k));
            chk("ld_wdata", 64'(wdata), 64'(exp_q.pop_front()));
            chk("ld_done", 64'(done), 64'(k == N - 1));
            cyc_end();
            dc_rsp.data_rvalid = 1'b0;
        end
        @(negedge clk);
        chk("rst_end_ready", 64'(ready), 64'd1);
        chk("rst_end_we", 64'(reg_we), 64'd0);
        cyc_end();
    endtask

    initial begin
        rst_n    = 1'b0;
        irq      = 1'b0;
        ret      = 1'b0;
        sp       = '0;
        page_off = 12'hFC8;
        dc_rsp   = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values.
        @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_we", 64'(reg_we), 64'd0);
        chk("reset_req", 64'(dc_req.data_req), 64'd0);
        chk("reset_tagv", 64'(dc_req.tag_valid), 64'd0);
        chk("reset_match", 64'(match), 64'd0);
        chk("reset_state", 64'(state), 64'd0);
        cyc_end();
        rst_n = 1'b1;
        cyc_end();

        // Single save with constant grant, request field encoding.
        do_save(32'h0000_1000, N, 1'b0);
        chk("single_level", 64'(level), 64'd1);
        page_off = 12'hFC8;
        @(negedge clk);
        chk("idle_match", 64'(match), 64'd0);
        chk("idle_size", 64'(dc_req.data_size), 64'd2);
        chk("idle_be", 64'(dc_req.data_be), 64'hF);
        chk("idle_kill", 64'(dc_req.kill_req), 64'd0);
        cyc_end();

        // Restore with gnt/rvalid stalls.
        do_restore(32'h0000_0FC0, 1'b1);
        chk("restore_level", 64'(level), 64'd0);

        // Nesting and overflow.
        do_save(32'h0000_1000, N, 1'b0);
        do_save(32'h0000_0F00, N, 1'b0);
        chk("nest_level", 64'(level), 64'd2);
        irq = 1'b1;
        @(negedge clk);
        chk("ovf_err", 64'(err), 64'd1);
        chk("ovf_req", 64'(dc_req.data_req), 64'd0);
        cyc_end();
        irq = 1'b0;
        @(negedge clk);
        chk("ovf_err_pulse", 64'(err), 64'd0);
        chk("ovf_ready", 64'(ready), 64'd1);
        chk("ovf_level", 64'(level), 64'd2);
        chk("ovf_req2", 64'(dc_req.data_req), 64'd0);
        cyc_end();
        do_restore(32'h0000_0EC0, 1'b0);
        chk("nest_level1", 64'(level), 64'd1);
        do_restore(32'h0000_0FC0, 1'b0);
        chk("nest_level0", 64'(level), 64'd0);

        // Underflow.
        ret = 1'b1;
        @(negedge clk);
        chk("unf_err", 64'(err), 64'd1);
        chk("unf_req", 64'(dc_req.data_req), 64'd0);
        cyc_end();
        ret = 1'b0;
        @(negedge clk);
        chk("unf_err_pulse", 64'(err), 64'd0);
        chk("unf_req2", 64'(dc_req.data_req), 64'd0);
        chk("unf_ready", 64'(ready), 64'd1);
        cyc_end();

        // irq and ret together: save only.
        do_save(32'h0000_1000, N, 1'b1);
        chk("simul_level", 64'(level), 64'd1);

        // Reset in the middle of a save.
        do_save(32'h0000_2000, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(ready), 64'd1);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_req", 64'(dc_req.data_req), 64'd0);
        @(negedge clk);
        chk("mid_rst_state", 64'(state), 64'd0);
        cyc_end();
        rst_n = 1'b1;
        ret = 1'b1;
        @(negedge clk);
        chk("post_rst_unf", 64'(err), 64'd1);
        cyc_end();
        ret = 1'b0;
        do_save(32'h0000_2000, N, 1'b0);
        chk("post_rst_level", 64'(level), 64'd1);
        do_restore(32'h0000_1FC0, 1'b1);
        chk("post_rst_level0", 64'(level), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
